rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Field-to-word RV32I instruction encoder and instruction-memory loader. It is the inverse of the control decoder.
- Accepts mnemonic-level instruction records (kind, rd, rs1, rs2, imm) over a valid/ready handshake.
- Emits the 32-bit machine word into the instruction-memory write port at consecutive word addresses.
- Used by the testbench and boot path to place programs into IMEM before the single-cycle core runs.

Parameters:
- ADDR_W, 32, width of the IMEM byte address.
- CNT_W, 16, width of the program-length counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begin a load session (ignored unless IDLE).
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are forced to 0.
- num_instr  in  CNT_W  number of records in the session.
- in_valid  in  1  record valid.
- in_ready  out  1  record accepted when in_valid & in_ready.
- in_kind  in  5  instruction kind code (package enum).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  signed byte immediate / offset; for LUI, the full upper value.
- im_we  out  1  IMEM write strobe (valid).
- im_ready  in  1  IMEM accepts the write this cycle.
- im_addr  out  ADDR_W  write byte address.
- im_wdata  out  32  encoded instruction word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky; set on an illegal kind or a range violation; cleared by start.

Behaviour:
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0. The FSM enters IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Latches base_addr and num_instr, clears err, resets the index k=0.
  - If num_instr==0, IDLE -> DONE directly.
  - RUN -> DRAIN when the last record (k==num_instr-1) is accepted.
  - DRAIN -> DONE when the output stage is empty.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- in_ready = (state==RUN) & (~im_we | im_ready). This is a single registered output stage; the skid is exactly one entry.
- Latency: a record accepted at cycle t appears as im_we=1 with its word at t+1.
- im_we, im_addr and im_wdata stay stable while im_we & ~im_ready. Never drop or duplicate a word.
- im_addr = base + 4*k; k increments per accepted record; address wraps mod 2^ADDR_W.
- Encoding per kind:
  - R: add, sub, and, or, xor, sll, srl, sra, slt, sltu.
  - I-alu: addi, andi, ori, xori.
  - I-shift: slli, srli, srai. shamt = imm[4:0]; funct7 0100000 for srai.
  - Load: lw, funct3 010.
  - S: sw, funct3 010.
  - B: beq, funct3 000.
  - U: lui, encodes imm[31:12].
  - J: jal.
  - Fields not used by a format encode as 0.
- Illegal kind code: emit NOP 0x00000013, set err, still count and write.
- start while busy: ignored. Reset mid-session: immediate return to IDLE with all outputs at reset values, no further writes.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- With the macro defined, range violations are checked:
  - I/S immediate outside [-2048, 2047].
  - Shift imm outside [0, 31].
  - B offset outside [-4096, 4094] or odd.
  - J offset outside [-2^20, 2^20-2] or odd.
  - LUI imm[11:0] != 0.
  - On a violation: set err and emit NOP in place of the word.
- Without the macro: immediates are silently truncated to field bits and err reflects illegal kinds only.

Decomposition:
- Package rv_enc_pkg holds:
  - the kind enum, 5-bit: KIND_ADD=0 … KIND_JAL=21, codes 22-31 illegal;
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111);
  - funct3/funct7 constants and the NOP constant.
- One combinational sub-module, rv_instr_pack, maps kind/fields/imm to {word, illegal, range_err}. The top holds the FSM, counter, address and output stage.

Test Plan:
- Session base=0x100, N=3; add x3,x1,x2; addi x1,x0,5; sw x2,8(x1); im_ready=1 -> writes 0x002081B3@0x100, 0x00500093@0x104, 0x0020A423@0x108; done one cycle after the last write; err=0.
- beq x1,x2,-4; lui x5,0x12345000; jal x1,8 -> words 0xFE208EE3, 0x123452B7, 0x008000EF.
- Backpressure: hold im_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled; im_wdata/im_addr unchanged; no word lost or repeated.
- Kind code 25 -> 0x00000013 written, err=1 held until the next start; with IMM_RANGE_CHECK_EN, addi imm=4096 -> NOP and err=1.
- N=0 -> done pulses the cycle after start, no im_we; start while busy is ignored.
- rstn=0 during RUN after 2 of 4 writes -> next cycle all outputs 0 and FSM in IDLE; a fresh session then works normally.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - RV32I encoder kind codes, opcodes, funct fields and FSM types
//
// Shared by rv_instr_pack and rv_instr_encoder. Kind codes 22..31 are
// illegal and encode as NOP.

package rv_enc_pkg;

    typedef enum logic [4:0] {
        KIND_ADD  = 5'd0,
        KIND_SUB  = 5'd1,
        KIND_AND  = 5'd2,
        KIND_OR   = 5'd3,
        KIND_XOR  = 5'd4,
        KIND_SLL  = 5'd5,
        KIND_SRL  = 5'd6,
        KIND_SRA  = 5'd7,
        KIND_SLT  = 5'd8,
        KIND_SLTU = 5'd9,
        KIND_ADDI = 5'd10,
        KIND_ANDI = 5'd11,
        KIND_ORI  = 5'd12,
        KIND_XORI = 5'd13,
        KIND_SLLI = 5'd14,
        KIND_SRLI = 5'd15,
        KIND_SRAI = 5'd16,
        KIND_LW   = 5'd17,
        KIND_SW   = 5'd18,
        KIND_BEQ  = 5'd19,
        KIND_LUI  = 5'd20,
        KIND_JAL  = 5'd21
    } kind_e;

    // Instruction format selected by the kind decode.
    typedef enum logic [3:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_LD,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Immediate limits used by the optional range check.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BOFF_MIN  = -4096;
    localparam int BOFF_MAX  = 4094;
    localparam int JOFF_MIN  = -(1 << 20);
    localparam int JOFF_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/rv_instr_pack.sv
// rtl/rv_instr_pack.sv - combinational RV32I field-to-word packer
//
// Ports:
//   kind_i       5   instruction kind code (kind_e; 22..31 illegal)
//   rd_i/rs1_i/rs2_i 5 register indices
//   imm_i        32  signed immediate / byte offset; full upper value for LUI
//   word_o       32  encoded instruction (NOP on illegal kind or range error)
//   illegal_o    1   kind code is not a defined kind
//   range_err_o  1   immediate does not fit its field (IMM_RANGE_CHECK_EN only)
//
// Build option: define IMM_RANGE_CHECK_EN to flag out-of-range immediates;
// otherwise immediates are truncated to their field bits.

module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  logic [4:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    fmt_e       fmt;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] raw_word;

    always_comb begin
        fmt = FMT_ILL;
        f3  = 3'b000;
        f7  = F7_BASE;
        case (kind_i)
            KIND_ADD:  begin fmt = FMT_R;  f3 = F3_ADD_SUB; end
            KIND_SUB:  begin fmt = FMT_R;  f3 = F3_ADD_SUB; f7 = F7_ALT; end
            KIND_AND:  begin fmt = FMT_R;  f3 = F3_AND;     end
            KIND_OR:   begin fmt = FMT_R;  f3 = F3_OR;      end
            KIND_XOR:  begin fmt = FMT_R;  f3 = F3_XOR;     end
            KIND_SLL:  begin fmt = FMT_R;  f3 = F3_SLL;     end
            KIND_SRL:  begin fmt = FMT_R;  f3 = F3_SRL_SRA; end
            KIND_SRA:  begin fmt = FMT_R;  f3 = F3_SRL_SRA; f7 = F7_ALT; end
            KIND_SLT:  begin fmt = FMT_R;  f3 = F3_SLT;     end
            KIND_SLTU: begin fmt = FMT_R;  f3 = F3_SLTU;    end
            KIND_ADDI: begin fmt = FMT_I;  f3 = F3_ADD_SUB; end
            KIND_ANDI: begin fmt = FMT_I;  f3 = F3_AND;     end
            KIND_ORI:  begin fmt = FMT_I;  f3 = F3_OR;      end
            KIND_XORI: begin fmt = FMT_I;  f3 = F3_XOR;     end
            KIND_SLLI: begin fmt = FMT_SH; f3 = F3_SLL;     end
            KIND_SRLI: begin fmt = FMT_SH; f3 = F3_SRL_SRA; end
            KIND_SRAI: begin fmt = FMT_SH; f3 = F3_SRL_SRA; f7 = F7_ALT; end
            KIND_LW:   begin fmt = FMT_LD; f3 = F3_LW;      end
            KIND_SW:   begin fmt = FMT_S;  f3 = F3_SW;      end
            KIND_BEQ:  begin fmt = FMT_B;  f3 = F3_BEQ;     end
            KIND_LUI:  begin fmt = FMT_U;  end
            KIND_JAL:  begin fmt = FMT_J;  end
            default:   begin fmt = FMT_ILL; end
        endcase
    end

    always_comb begin
        raw_word  = NOP_WORD;
        illegal_o = 1'b0;
        case (fmt)
            FMT_R:  raw_word = {f7, rs2_i, rs1_i, f3, rd_i, OPC_OP};
            FMT_I:  raw_word = {imm_i[11:0], rs1_i, f3, rd_i, OPC_OP_IMM};
            FMT_SH: raw_word = {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_OP_IMM};
            FMT_LD: raw_word = {imm_i[11:0], rs1_i, f3, rd_i, OPC_LOAD};
            FMT_S:  raw_word = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], OPC_STORE};
            FMT_B:  raw_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                                imm_i[4:1], imm_i[11], OPC_BRANCH};
            FMT_U:  raw_word = {imm_i[31:12], rd_i, OPC_LUI};
            FMT_J:  raw_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                                rd_i, OPC_JAL};
            default: begin
                raw_word  = NOP_WORD;
                illegal_o = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm_i);

    always_comb begin
        range_err_o = 1'b0;
        case (fmt)
            FMT_I, FMT_LD, FMT_S: range_err_o = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            // Unsigned compare also rejects negative shift amounts.
            FMT_SH: range_err_o = (imm_i > 32'd31);
            FMT_B:  range_err_o = (simm < BOFF_MIN) || (simm > BOFF_MAX) || imm_i[0];
            FMT_J:  range_err_o = (simm < JOFF_MIN) || (simm > JOFF_MAX) || imm_i[0];
            FMT_U:  range_err_o = (imm_i[11:0] != 12'h000);
            default: range_err_o = 1'b0;
        endcase
    end

    assign word_o = range_err_o ? NOP_WORD : raw_word;
`else
    assign range_err_o = 1'b0;
    assign word_o      = raw_word;
`endif

endmodule

// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - RV32I record encoder and IMEM loader
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   start              pulse; begins a session when IDLE (ignored otherwise)
//   base_addr, num_instr  first word byte address (low 2 bits dropped), record count
//   in_valid/in_ready  record handshake; in_kind/in_rd/in_rs1/in_rs2/in_imm fields
//   im_we/im_ready     IMEM write handshake; im_addr/im_wdata write address/word
//   busy, done, err    state != IDLE, session-end pulse, sticky error
//
// Build option: IMM_RANGE_CHECK_EN (see rv_instr_pack) adds immediate
// range errors to err.

module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              err_q, err_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        pack_range_err;
    logic        accept;
    logic        last_rec;

    rv_instr_pack u_pack (
        .kind_i      (in_kind),
        .rd_i        (in_rd),
        .rs1_i       (in_rs1),
        .rs2_i       (in_rs2),
        .imm_i       (in_imm),
        .word_o      (pack_word),
        .illegal_o   (pack_illegal),
        .range_err_o (pack_range_err)
    );

    // Single output register: a new record may enter only when that
    // register is empty or being drained this cycle.
    assign in_ready = (state_q == ST_RUN) && (!im_we_q || im_ready);
    assign accept   = in_valid && in_ready;
    assign last_rec = (k_q == num_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_instr == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_rec) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!im_we_q || im_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        next_addr_d = next_addr_q;
        k_d         = k_q;
        num_d       = num_q;
        err_d       = err_q;
        im_we_d     = im_we_q;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;

        if (state_q == ST_IDLE && start) begin
            next_addr_d = base_addr & ~ADDR_W'(3);
            k_d         = '0;
            num_d       = num_instr;
            err_d       = 1'b0;
        end

        if (accept) begin
            im_we_d     = 1'b1;
            im_addr_d   = next_addr_q;
            im_wdata_d  = pack_word;
            next_addr_d = next_addr_q + ADDR_W'(4);
            k_d         = k_q + CNT_W'(1);
            if (pack_illegal || pack_range_err) begin
                err_d = 1'b1;
            end
        end else if (im_ready) begin
            im_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            k_q         <= '0;
            num_q       <= '0;
            err_q       <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            k_q         <= k_d;
            num_q       <= num_d;
            err_q       <= err_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb/tb_rv_instr_encoder.sv - self-checking bench for rv_instr_encoder

module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_instr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        im_we;
    logic        im_ready;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    rv_instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .num_instr (num_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .im_we     (im_we),
        .im_ready  (im_ready),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [4:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t tab [12];

`ifdef IMM_RANGE_CHECK_EN
    localparam bit          RANGE_ON   = 1'b1;
    localparam logic [31:0] ADDI4096_W = 32'h0000_0013;
`else
    localparam bit          RANGE_ON   = 1'b0;
    localparam logic [31:0] ADDI4096_W = 32'h0000_0093;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          last_wr_cyc = 0;
    logic [63:0] exp_q [$];
    bit          held = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic [63:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event, want one", name);
    endtask

    // Scoreboard side: every completed IMEM write is popped and compared;
    // a stalled write must hold address and data until it completes.
    always @(negedge clk) begin
        if (!rstn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                if (!im_we) begin
                    fail_now("word_dropped_in_stall");
                end else begin
                    check("stall_addr_stable", im_addr, held_addr);
                    check("stall_data_stable", im_wdata, held_data);
                end
            end
            if (im_we) begin
                if (im_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = exp_q.pop_front();
                        check("im_addr", im_addr, e[63:32]);
                        check("im_wdata", im_wdata, e[31:0]);
                    end
                    wr_cnt++;
                    last_wr_cyc = cyc;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_addr = im_addr;
                    held_data = im_wdata;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send(input int idx, input logic [31:0] addr);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_kind  = tab[idx].kind;
        in_rd    = tab[idx].rd;
        in_rs1   = tab[idx].rs1;
        in_rs2   = tab[idx].rs2;
        in_imm   = tab[idx].imm;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({addr, tab[idx].word});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) fail_now("accept_timeout");
    endtask

    task automatic run_session(input logic [31:0] base, input int first, input int n,
                               input bit exp_err);
        logic [31:0] a;
        int          wr0;
        bit          seen;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        num_instr = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", err, 0);
        a = base & ~32'd3;
        for (int j = 0; j < n; j++) begin
            send(first + j, a);
            a = a + 32'd4;
        end
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            fail_now("done_timeout");
        end else begin
            check("done_after_last_write", cyc, last_wr_cyc + 1);
        end
        check("write_count", wr_cnt - wr0, n);
        check("queue_empty", exp_q.size(), 0);
        check("session_err", err, exp_err);
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int  wr0;
        bit  ok;

        //            kind   rd     rs1    rs2    imm            word
        tab[0]  = '{5'd0,  5'd3,  5'd1,  5'd2,  32'd0,         32'h002081B3}; // add x3,x1,x2
        tab[1]  = '{5'd10, 5'd1,  5'd0,  5'd0,  32'd5,         32'h00500093}; // addi x1,x0,5
        tab[2]  = '{5'd18, 5'd0,  5'd1,  5'd2,  32'd8,         32'h0020A423}; // sw x2,8(x1)
        tab[3]  = '{5'd19, 5'd0,  5'd1,  5'd2,  -32'sd4,       32'hFE208EE3}; // beq x1,x2,-4
        tab[4]  = '{5'd20, 5'd5,  5'd0,  5'd0,  32'h12345000,  32'h123452B7}; // lui x5
        tab[5]  = '{5'd21, 5'd1,  5'd0,  5'd0,  32'd8,         32'h008000EF}; // jal x1,8
        tab[6]  = '{5'd1,  5'd5,  5'd6,  5'd7,  32'd0,         32'h407302B3}; // sub x5,x6,x7
        tab[7]  = '{5'd16, 5'd4,  5'd2,  5'd0,  32'd3,         32'h40315213}; // srai x4,x2,3
        tab[8]  = '{5'd17, 5'd6,  5'd2,  5'd0,  -32'sd8,       32'hFF812303}; // lw x6,-8(x2)
        tab[9]  = '{5'd25, 5'd1,  5'd2,  5'd3,  32'd7,         32'h00000013}; // illegal kind
        tab[10] = '{5'd9,  5'd10, 5'd11, 5'd12, 32'd0,         32'h00C5B533}; // sltu x10,x11,x12
        tab[11] = '{5'd10, 5'd1,  5'd0,  5'd0,  32'd4096,      ADDI4096_W};   // addi x1,x0,4096

        rstn      = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_instr = '0;
        in_valid  = 1'b0;
        in_kind   = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        im_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rstn = 1'b1;

        // Basic session.
        run_session(32'h0000_0100, 0, 3, 1'b0);

        // Remaining formats, misaligned base, start while busy, backpressure.
        fork
            run_session(32'h0000_0203, 3, 6, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                start     = 1'b1;
                base_addr = 32'h0000_0900;
                num_instr = 16'd1;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(posedge clk);
                #1;
                im_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_im_we", im_we, 1);
                    @(posedge clk);
                    #1;
                end
                im_ready = 1'b1;
            end
        join

        // Illegal kind, address wrap past 2^32.
        run_session(32'hFFFF_FFFC, 9, 2, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("err_sticky", err, 1);
        end

        // Empty session: done the cycle after start, no write, err cleared.
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 32'h0000_0500;
        num_instr = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("n0_done", done, 1);
        check("n0_im_we", im_we, 0);
        check("n0_err_cleared", err, 0);
        @(posedge clk);
        #1;
        check("n0_done_clear", done, 0);
        check("n0_idle", busy, 0);
        check("n0_no_writes", wr_cnt - wr0, 0);

        // Out-of-range immediate.
        run_session(32'h0000_0300, 11, 1, RANGE_ON);

        // Reset during RUN after two of four writes.
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 32'h0000_0400;
        num_instr = 16'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(0, 32'h0000_0400);
        send(1, 32'h0000_0404);
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (wr_cnt - wr0 >= 2) ok = 1'b1;
        end
        if (!ok) fail_now("two_writes_timeout");
        check("pre_reset_busy", busy, 1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_im_we", im_we, 0);
        check("mid_rst_im_addr", im_addr, 0);
        check("mid_rst_im_wdata", im_wdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        rstn = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_writes", wr_cnt - wr0, 2);
        check("post_rst_idle", busy, 0);

        // Fresh session after reset.
        run_session(32'h0000_0100, 0, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
